// File: rtl/cell_writer_pkg.sv
// Shared definitions for the arena port b engines (cell_reader / cell_writer):
// row-address width, default arena dimensions and the writer FSM encoding.
package cell_writer_pkg;

   localparam int unsigned RowAddrW       = 8;
   localparam int unsigned DefArenaWidth  = 10;
   localparam int unsigned DefArenaHeight = 10;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRead    = 3'd1,
      StCapture = 3'd2,
      StWrite   = 3'd3,
      StSkip    = 3'd4
   } cw_state_e;

endpackage

// File: rtl/cell_writer.sv
// Single-cell write engine for arena port b: read-modify-write of one row so
// that only the addressed bit is set, cleared or inverted.
module cell_writer
   import cell_writer_pkg::*;
#(
   parameter int unsigned ARENA_WIDTH  = DefArenaWidth,
   parameter int unsigned ARENA_HEIGHT = DefArenaHeight
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   ready,
   input  logic [RowAddrW-1:0]    cell_column,
   input  logic [RowAddrW-1:0]    cell_row,
   input  logic                   cell_value,
   input  logic                   cell_toggle,
   output logic [RowAddrW-1:0]    arena_row_select,
   input  logic [ARENA_WIDTH-1:0] arena_columns_in,
   output logic [ARENA_WIDTH-1:0] arena_columns_out,
   output logic                   arena_write
);

   cw_state_e             state_q, state_d;
   logic [RowAddrW-1:0]    col_q, col_d;
   logic [RowAddrW-1:0]    row_q, row_d;
   logic                   val_q, val_d;
   logic                   tog_q, tog_d;
   logic [RowAddrW-1:0]    row_sel_q, row_sel_d;
   logic [ARENA_WIDTH-1:0] buf_q, buf_d;
   logic                   in_range;

   // Replace bit[col] of a row with val, or with its inverse when tog is set.
   function automatic logic [ARENA_WIDTH-1:0] merge_cell(
      input logic [ARENA_WIDTH-1:0] row_bits,
      input logic [RowAddrW-1:0]    col,
      input logic                   val,
      input logic                   tog
   );
      logic [ARENA_WIDTH-1:0] mask;
      logic                   bit_new;
      mask    = ARENA_WIDTH'(1) << col;
      bit_new = tog ? ~|(row_bits & mask) : val;
      return bit_new ? (row_bits | mask) : (row_bits & ~mask);
   endfunction

   assign in_range = (32'(cell_column) < ARENA_WIDTH) && (32'(cell_row) < ARENA_HEIGHT);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      val_d     = val_q;
      tog_d     = tog_q;
      row_sel_d = row_sel_q;
      buf_d     = buf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               col_d = cell_column;
               row_d = cell_row;
               val_d = cell_value;
               tog_d = cell_toggle;
               if (in_range) begin
                  row_sel_d = cell_row;
                  state_d   = StRead;
               end else begin
                  state_d = StSkip;
               end
            end
         end
         StRead:    state_d = StCapture;
         StCapture: begin
            buf_d   = merge_cell(arena_columns_in, col_q, val_q, tog_q);
            state_d = StWrite;
         end
         StWrite:   state_d = StIdle;
         StSkip:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         col_q     <= '0;
         row_q     <= '0;
         val_q     <= 1'b0;
         tog_q     <= 1'b0;
         row_sel_q <= '0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         val_q     <= val_d;
         tog_q     <= tog_d;
         row_sel_q <= row_sel_d;
         buf_q     <= buf_d;
      end
   end

   assign ready             = (state_q == StIdle);
   assign arena_row_select  = row_sel_q;
   assign arena_columns_out = buf_q;
   // Gated by reset so a reset landing in the WRITE cycle never commits a row.
   assign arena_write       = (state_q == StWrite) && !reset;

endmodule

// File: tb/tb_cell_writer.sv
// Directed bench for cell_writer against a 10x10 arena model with one-cycle
// synchronous read and a bench-side preload mux.
module tb_cell_writer;

   localparam int W = 10;
   localparam int H = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         ready;
   logic [7:0]   cell_column, cell_row;
   logic         cell_value, cell_toggle;
   logic [7:0]   arena_row_select;
   logic [W-1:0] arena_columns_in, arena_columns_out;
   logic         arena_write;

   logic [W-1:0] mem [0:H-1];
   logic         tb_we;
   logic [7:0]   tb_row;
   logic [W-1:0] tb_data;
   int           wr_cnt;

   int tests = 0;
   int fails = 0;

   cell_writer #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .ready             (ready),
      .cell_column       (cell_column),
      .cell_row          (cell_row),
      .cell_value        (cell_value),
      .cell_toggle       (cell_toggle),
      .arena_row_select  (arena_row_select),
      .arena_columns_in  (arena_columns_in),
      .arena_columns_out (arena_columns_out),
      .arena_write       (arena_write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      arena_columns_in <= (arena_row_select < 8'(H)) ? mem[arena_row_select] : '0;
      if (tb_we) mem[tb_row] <= tb_data;
      else if (arena_write && arena_row_select < 8'(H)) mem[arena_row_select] <= arena_columns_out;
      if (arena_write) wr_cnt <= wr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int r, input logic [W-1:0] d);
      tb_we = 1'b1; tb_row = 8'(r); tb_data = d;
      tick();
      tb_we = 1'b0;
   endtask

   // Full valid request: ready low for 3 cycles, one write on the third.
   task automatic do_req(input string tag, input int c, input int r, input logic v,
                         input logic t, input logic [W-1:0] exp_row);
      int wc0;
      wc0 = wr_cnt;
      cell_column = 8'(c); cell_row = 8'(r); cell_value = v; cell_toggle = t;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " ready_e0"}, 32'(ready), 32'd0);
      tick();
      chk({tag, " ready_e1"}, 32'(ready), 32'd0);
      tick();
      chk({tag, " write_e2"}, 32'(arena_write), 32'd1);
      chk({tag, " sel_e2"}, 32'(arena_row_select), 32'(r));
      chk({tag, " out_e2"}, 32'(arena_columns_out), 32'(exp_row));
      tick();
      chk({tag, " ready_e3"}, 32'(ready), 32'd1);
      chk({tag, " write_e3"}, 32'(arena_write), 32'd0);
      chk({tag, " mem"}, 32'(mem[r]), 32'(exp_row));
      chk({tag, " wr_cnt"}, 32'(wr_cnt - wc0), 32'd1);
   endtask

   initial begin
      int wc0;
      int acc;
      int idx;
      logic was_ready;

      reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_row = '0; tb_data = '0;
      cell_column = '0; cell_row = '0; cell_value = 1'b0; cell_toggle = 1'b0;
      wr_cnt = 0;
      for (int r = 0; r < H; r++) preload(r, '0);
      tick();
      chk("rst ready", 32'(ready), 32'd1);
      chk("rst sel", 32'(arena_row_select), 32'd0);
      chk("rst out", 32'(arena_columns_out), 32'd0);
      chk("rst write", 32'(arena_write), 32'd0);
      reset = 1'b0;
      tick();

      // Basic set
      do_req("set c3r2", 3, 2, 1'b1, 1'b0, 10'h008);
      chk("row1 untouched", 32'(mem[1]), 32'd0);
      chk("row3 untouched", 32'(mem[3]), 32'd0);

      // Clear and toggles on a full row
      preload(5, 10'h3FF);
      do_req("clr c0r5", 0, 5, 1'b0, 1'b0, 10'h3FE);
      do_req("tog1 c9r5", 9, 5, 1'b1, 1'b1, 10'h1FE);
      do_req("tog2 c9r5", 9, 5, 1'b0, 1'b1, 10'h3FE);

      // Out-of-range requests
      wc0 = wr_cnt;
      cell_column = 8'd10; cell_row = 8'd0; cell_value = 1'b1; cell_toggle = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("oor col ready_e0", 32'(ready), 32'd0);
      chk("oor col write", 32'(arena_write), 32'd0);
      tick();
      chk("oor col ready_e1", 32'(ready), 32'd1);
      chk("oor col sel held", 32'(arena_row_select), 32'd5);
      cell_column = 8'd0; cell_row = 8'd10;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("oor row ready_e0", 32'(ready), 32'd0);
      tick();
      chk("oor row ready_e1", 32'(ready), 32'd1);
      tick();
      chk("oor no writes", 32'(wr_cnt - wc0), 32'd0);
      chk("oor row0", 32'(mem[0]), 32'd0);

      // Start held high: back-to-back diagonal
      wc0 = wr_cnt;
      acc = 0; idx = 0;
      cell_column = 8'd0; cell_row = 8'd0; cell_value = 1'b1; cell_toggle = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         was_ready = ready;
         tick();
         if (was_ready) begin
            acc++;
            idx++;
            cell_column = 8'(idx); cell_row = 8'(idx);
         end
      end
      start = 1'b0;
      chk("b2b accepted", 32'(acc), 32'd3);
      chk("b2b writes", 32'(wr_cnt - wc0), 32'd3);
      chk("b2b row0", 32'(mem[0]), 32'h001);
      chk("b2b row1", 32'(mem[1]), 32'h002);
      chk("b2b row2", 32'(mem[2]), 32'h00C);
      chk("b2b row3", 32'(mem[3]), 32'h000);
      tick();

      // Reset during READ
      wc0 = wr_cnt;
      cell_column = 8'd4; cell_row = 8'd3; cell_value = 1'b1; cell_toggle = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_rd ready", 32'(ready), 32'd1);
      tick(); tick(); tick();
      chk("rst_rd no write", 32'(wr_cnt - wc0), 32'd0);
      chk("rst_rd row3", 32'(mem[3]), 32'd0);

      // Reset during WRITE
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      #1;
      chk("rst_wr write gated", 32'(arena_write), 32'd0);
      tick();
      reset = 1'b0;
      chk("rst_wr ready", 32'(ready), 32'd1);
      tick();
      chk("rst_wr no write", 32'(wr_cnt - wc0), 32'd0);
      chk("rst_wr row3", 32'(mem[3]), 32'd0);
      do_req("after rst", 4, 3, 1'b1, 1'b0, 10'h010);

      // Inputs changed after acceptance are ignored
      cell_column = 8'd1; cell_row = 8'd7; cell_value = 1'b1; cell_toggle = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cell_column = 8'd8; cell_row = 8'd4; cell_value = 1'b0; cell_toggle = 1'b1;
      tick(); tick();
      chk("latch sel", 32'(arena_row_select), 32'd7);
      chk("latch out", 32'(arena_columns_out), 32'h002);
      tick();
      chk("latch row7", 32'(mem[7]), 32'h002);
      chk("latch row4", 32'(mem[4]), 32'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cell_writer.md
Name: cell_writer

Overview:
- Single-cell write engine for the arena's port b. It is the write-side counterpart of cell_reader.
- Accepts a (column, row, value) request and performs a read-modify-write of one arena row, so only the addressed bit changes.
- Sits between the simulation/edit control logic and the arena memory.
- Shares the arena port b row-select/columns interface style with cell_reader.

Parameters:
- ARENA_WIDTH, 10, number of columns (bits per arena row), 1..256.
- ARENA_HEIGHT, 10, number of rows, 1..256.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request strobe; sampled only while ready=1.
- ready  output  1  high when idle and able to accept a request.
- cell_column  input  8  target column; bit index within the row.
- cell_row  input  8  target row.
- cell_value  input  1  value to write (ignored when cell_toggle=1).
- cell_toggle  input  1  1: invert the current cell instead of writing cell_value.
- arena_row_select  output  8  arena port b row address.
- arena_columns_in  input  ARENA_WIDTH  arena port b read data; one-cycle synchronous read latency.
- arena_columns_out  output  ARENA_WIDTH  arena port b write data.
- arena_write  output  1  arena port b write enable.

Behaviour:
- Reset values: ready=1, arena_row_select=0, arena_columns_out=0, arena_write=0, state=IDLE.
- Bit mapping: column c is bit c of the row vector; bit 0 is column 0.
- FSM states: IDLE, READ, CAPTURE, WRITE, SKIP.
- IDLE: ready=1. On start=1 at edge E0:
  - Latch column, row, value and toggle; ready drops to 0.
  - If column >= ARENA_WIDTH or row >= ARENA_HEIGHT, go to SKIP. Otherwise drive arena_row_select=row and go to READ.
- READ (E0..E1): row address presented; the arena samples it at E1. Next state: CAPTURE.
- CAPTURE (E1..E2): arena_columns_in is valid. At E2:
  - Register the row into a buffer with bit[column] replaced by the latched value, or by its inverse when toggle=1.
  - Next state: WRITE.
- WRITE (E2..E3): arena_write=1 and arena_columns_out=buffer; arena_row_select still equals row. At E3, return to IDLE.
- Timing: ready is low for exactly 3 cycles and high again after E3. Exactly one arena_write cycle per valid request.
- SKIP (E0..E1): no arena write, arena_row_select unchanged. At E1, return to IDLE, so ready is low for 1 cycle.
- start while ready=0 is ignored. Requests are not queued.
- start held high in IDLE after a completion is accepted as a new request (back-to-back, one request per 4 cycles).
- Latched request fields are held internally; input changes after E0 have no effect on the request in progress.
- arena_row_select holds its last value in IDLE.
- arena_columns_out holds the buffer value; it is only meaningful while arena_write=1.
- arena_write = (state==WRITE) && !reset, so reset asserted in the WRITE cycle suppresses the write.
- Reset in any state: IDLE at the next edge, ready=1, no write issued, latched request discarded.
- Port b is owned exclusively during READ/CAPTURE/WRITE; arbitration with cell_reader is external.

Decomposition:
- Shared package/header (shared with cell_reader): arena row-address width (8), default arena dimensions, FSM state encodings.
- No sub-module. The bit-replace/toggle merge is a single combinational function inside the block.

Test Plan (arena 10x10, bench preloads all rows to 0 via a write mux as in the cell_reader bench):
- start, col=3, row=2, value=1, toggle=0 -> ready low 3 cycles; arena_write high exactly 1 cycle with row_select=2, columns_out=10'b0000001000. Reading back row 2 gives 10'h008; other rows stay 0.
- Preload row 5=10'h3FF; write col=0, row=5, value=0 -> row 5 becomes 10'h3FE. Then toggle col=9, row=5 -> 10'h1FE; toggle col=9 again -> 10'h3FE.
- col=10, row=0 (out of range) and col=0, row=10 -> ready low 1 cycle each, arena_write never asserted, arena contents unchanged.
- start held high for 12 cycles with col=i and row=i, where i increments after each acceptance -> 3 accepted requests, one per 4 cycles; diagonal bits 0..2 set; start during busy cycles ignored.
- Assert reset in the READ cycle, and separately in the WRITE cycle -> no write occurs, ready=1 on the following cycle, row unchanged. A subsequent request completes normally.
- Change cell_column/cell_row/cell_value during the READ cycle -> the write uses the values latched at E0.
